// File: rtl/cam_pix_capture.sv
// Frames a vsync/href RGB565 byte stream into addressed RGB888 words. Push on the low-byte edge, wr_en the next cycle.
// Backpressure: a pixel that meets a full FIFO is dropped and flagged, and its address slot is still consumed.
module cam_pix_capture #(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [23:0] BASE_ADDR  = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_req,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  cam_data,
    input  logic        wr_rdy,
    output logic        wr_en,
    output logic [23:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow,
    output logic        line_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0] COL_END   = CW'(H_ACTIVE);
    localparam logic [LW-1:0] LAST_LINE = LW'(V_ACTIVE - 1);
    localparam logic [23:0]   LINE_STEP = 24'(H_ACTIVE);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, FLUSH} state_t;
    state_t state_q, state_d;

    logic          vsync_q, href_q;
    logic [LW-1:0] line;
    logic [CW-1:0] col;
    logic          phase;
    logic [7:0]    hi_byte;
    logic [23:0]   addr_cnt, line_base;

    logic [23:0]   fifo_addr [FIFO_DEPTH];
    logic [23:0]   fifo_rgb  [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;

    logic        empty, full;
    logic        vsync_rise, vsync_fall, href_rise, href_fall;
    logic        byte_phase, capture, in_line, push, pop, start;
    logic [15:0] pix;
    logic [23:0] rgb;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign vsync_rise = vsync & ~vsync_q;
    assign vsync_fall = ~vsync & vsync_q;
    assign href_rise  = href & ~href_q;
    assign href_fall  = ~href & href_q;

    // The first byte of every line is a high byte, whatever the previous line left behind.
    assign byte_phase = href_rise ? 1'b0 : phase;
    assign capture    = (state_q == ACTIVE) && !vsync_rise && href;
    assign in_line    = (col < COL_END);
    assign push       = capture && byte_phase && in_line && !full;
    assign pop        = !empty && wr_rdy;
    assign start      = (state_q == IDLE) && cap_req;

    assign pix = {hi_byte, cam_data};
    assign rgb = {pix[15:11], pix[15:13], pix[10:5], pix[10:9], pix[4:0], pix[4:2]};

    assign wr_en   = !empty;
    assign wr_addr = empty ? 24'h0 : fifo_addr[rd_ptr];
    assign wr_data = empty ? 32'h0 : {8'h00, fifo_rgb[rd_ptr]};
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap_req) state_d = SYNC;
            SYNC:    if (vsync_fall) state_d = ACTIVE;
            ACTIVE:  if (vsync_rise || (href_fall && line == LAST_LINE)) state_d = FLUSH;
            FLUSH:   if (empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            line_err   <= 1'b0;
            line       <= '0;
            col        <= '0;
            phase      <= 1'b0;
            hi_byte    <= 8'h00;
            addr_cnt   <= 24'h0;
            line_base  <= 24'h0;
        end else begin
            vsync_q    <= vsync;
            href_q     <= href;
            frame_done <= (state_q == FLUSH) && empty;
            if (start || (state_q == SYNC && vsync_fall)) begin
                line      <= '0;
                col       <= '0;
                phase     <= 1'b0;
                addr_cnt  <= BASE_ADDR;
                line_base <= BASE_ADDR;
            end
            if (start) begin
                overflow <= 1'b0;
                line_err <= 1'b0;
            end
            if (state_q == ACTIVE && vsync_rise) line_err <= 1'b1;
            if (capture) begin
                phase <= ~byte_phase;
                if (!byte_phase) begin
                    hi_byte <= cam_data;
                end else if (in_line) begin
                    col      <= col + CW'(1);
                    addr_cnt <= addr_cnt + 24'd1;
                    if (full) overflow <= 1'b1;
                end
            end
            // Line end re-derives the address from the line base so drops never skew later lines.
            if (state_q == ACTIVE && !vsync_rise && href_fall) begin
                if (col != COL_END || phase) line_err <= 1'b1;
                line      <= line + LW'(1);
                col       <= '0;
                line_base <= line_base + LINE_STEP;
                addr_cnt  <= line_base + LINE_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (!push && pop) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= addr_cnt;
            fifo_rgb[wr_ptr]  <= rgb;
        end
    end
endmodule

// File: tb/tb_cam_pix_capture.sv
// Bench for cam_pix_capture: byte-stream stimulus with a pixel/address/occupancy reference model.
`timescale 1ns/1ps
module tb_cam_pix_capture;
    localparam int          H    = 6;
    localparam int          V    = 2;
    localparam int          D    = 4;
    localparam logic [23:0] BASE = 24'h000100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_req = 1'b0, vsync = 1'b0, href = 1'b0, wr_rdy = 1'b1;
    logic [7:0]  cam_data = 8'h00;
    logic        wr_en, busy, frame_done, overflow, line_err;
    logic [23:0] wr_addr;
    logic [31:0] wr_data;

    cam_pix_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .cap_req(cap_req), .vsync(vsync), .href(href),
        .cam_data(cam_data), .wr_rdy(wr_rdy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
        .overflow(overflow), .line_err(line_err)
    );

    always #5 clk = ~clk;

    int          errors = 0, checks = 0, occ = 0, fd_cnt = 0, fd0 = 0;
    logic        fd_busy = 1'b0, ovf_exp = 1'b0, lerr_exp = 1'b0;
    logic [55:0] exp_q[$];
    logic [55:0] obs_q[$];
    logic [7:0]  lb[$];

    function automatic logic [31:0] rgb888(input logic [15:0] p);
        int r, g, b;
        r = int'(p) / 2048;
        g = (int'(p) / 32) % 64;
        b = int'(p) % 32;
        return 32'((r * 8 + r / 4) * 65536 + (g * 4 + g / 16) * 256 + (b * 8 + b / 4));
    endfunction

    // One clock: observe outputs before the edge, then advance the FIFO occupancy model.
    task automatic cyc(input bit push, input logic [55:0] w);
        bit pop;
        #1;
        if (wr_en && wr_rdy) obs_q.push_back({wr_addr, wr_data});
        if (frame_done) begin
            fd_cnt++;
            fd_busy = busy;
        end
        pop = (occ > 0) && wr_rdy;
        if (push) begin
            if (occ == D) ovf_exp = 1'b1;
            else begin
                exp_q.push_back(w);
                occ++;
            end
        end
        if (pop) occ--;
        @(negedge clk);
    endtask

    task automatic drive_rdy(input int mode);
        wr_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic fill_random(input int nbytes);
        lb.delete();
        for (int k = 0; k < nbytes; k++) lb.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_line(input int line, input int mode);
        logic [7:0] hi;
        int col;
        hi = 8'h00;
        for (int k = 0; k < lb.size(); k++) begin
            href = 1'b1;
            cam_data = lb[k];
            drive_rdy(mode);
            if (k % 2 == 0) begin
                hi = lb[k];
                cyc(1'b0, 56'd0);
            end else begin
                col = k / 2;
                if (col < H) cyc(1'b1, {BASE + 24'(line * H + col), rgb888({hi, lb[k]})});
                else         cyc(1'b0, 56'd0);
            end
        end
        href = 1'b0;
        cam_data = 8'h00;
        drive_rdy(mode);
        cyc(1'b0, 56'd0);
        if ((lb.size() % 2) != 0 || lb.size() / 2 < H) lerr_exp = 1'b1;
        cyc(1'b0, 56'd0);
    endtask

    task automatic start_frame();
        exp_q.delete();
        obs_q.delete();
        fd0 = fd_cnt;
        href = 1'b0;
        vsync = 1'b0;
        wr_rdy = 1'b1;
        cap_req = 1'b1;
        cyc(1'b0, 56'd0);
        cap_req = 1'b0;
        ovf_exp = 1'b0;
        lerr_exp = 1'b0;
        vsync = 1'b1;
        cyc(1'b0, 56'd0);
        cyc(1'b0, 56'd0);
        vsync = 1'b0;
        cyc(1'b0, 56'd0);
        cyc(1'b0, 56'd0);
    endtask

    task automatic wait_done();
        int s;
        s = fd_cnt;
        href = 1'b0;
        wr_rdy = 1'b1;
        for (int n = 0; n < 200 && fd_cnt == s; n++) cyc(1'b0, 56'd0);
        cyc(1'b0, 56'd0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data, busy, frame_done, overflow, line_err} !== 61'd0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b addr=%h data=%h busy=%b done=%b ovf=%b lerr=%b required all zero",
                     wr_en, wr_addr, wr_data, busy, frame_done, overflow, line_err);
        end
        rst = 1'b0;
        cyc(1'b0, 56'd0);
        start_frame();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_req got=%b required=1", busy); end
        fill_random(4);
        for (int k = 0; k < 4; k++) begin
            href = 1'b1;
            cam_data = lb[k];
            wr_rdy = 1'b0;
            cyc(k % 2 == 1, {BASE + 24'(k / 2), rgb888({lb[k - (k % 2)], lb[k]})});
        end
        checks++;
        if (wr_en !== (occ > 0) || wr_addr !== BASE) begin
            errors++;
            $display("FAIL queued_before_reset got en=%b addr=%h required en=1 addr=%h", wr_en, wr_addr, BASE);
        end
        rst = 1'b1;
        href = 1'b0;
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, busy, frame_done, overflow, line_err} !== 61'd0) begin
            errors++;
            $display("FAIL mid_frame_reset got en=%b addr=%h data=%h busy=%b required all zero", wr_en, wr_addr, wr_data, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        occ = 0;
        wr_rdy = 1'b1;
        cyc(1'b0, 56'd0);
        start_frame();
        for (int l = 0; l < V; l++) begin
            fill_random(2 * H);
            send_line(l, 0);
        end
        wait_done();
        checks++;
        if (obs_q.size() !== exp_q.size() || obs_q.size() == 0 || obs_q[0][55:32] !== BASE) begin
            errors++;
            $display("FAIL restart_frame got words=%0d first_addr=%h required words=%0d first_addr=%h",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0][55:32] : 24'h0, exp_q.size(), BASE);
        end
        checks++;
        if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL restart_done got=%0d required=1", fd_cnt - fd0); end
    endtask

    task automatic test_normal_frame();
        start_frame();
        for (int l = 0; l < V; l++) begin
            lb = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
            lb.push_back(8'($urandom_range(0, 255)));
            lb.push_back(8'($urandom_range(0, 255)));
            lb.push_back(8'($urandom_range(0, 255)));
            lb.push_back(8'($urandom_range(0, 255)));
            send_line(l, 0);
        end
        wait_done();
        checks++;
        if (obs_q.size() < 4 || obs_q[0][31:0] !== 32'h00FF0000 || obs_q[1][31:0] !== 32'h0000FF00 ||
            obs_q[2][31:0] !== 32'h000000FF || obs_q[3][31:0] !== 32'h00FFFFFF) begin
            errors++;
            $display("FAIL normal_colours got words=%0d required FF0000,00FF00,0000FF,FFFFFF", obs_q.size());
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL normal_count got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL normal_word[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (fd_cnt - fd0 != 1 || fd_busy !== 1'b0 || {overflow, line_err} !== 2'b00) begin
            errors++;
            $display("FAIL normal_done got pulses=%0d busy=%b ovf=%b lerr=%b required 1,0,0,0",
                     fd_cnt - fd0, fd_busy, overflow, line_err);
        end
    endtask

    task automatic test_backpressure();
        start_frame();
        fill_random(2 * H);
        send_line(0, 1);
        checks++;
        if (overflow !== 1'b1 || wr_en !== 1'b1 || occ != D) begin
            errors++;
            $display("FAIL bp_overflow got ovf=%b en=%b required ovf=1 en=1 (model occ=%0d)", overflow, wr_en, occ);
        end
        fill_random(2 * H);
        send_line(1, 0);
        wait_done();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL bp_count got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_word[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q.size() < 5 || obs_q[3][55:32] !== BASE + 24'd3 || obs_q[4][55:32] !== BASE + 24'd6) begin
            errors++;
            $display("FAIL bp_next_line_addr got words=%0d required addr[3]=%h addr[4]=%h", obs_q.size(), BASE + 24'd3, BASE + 24'd6);
        end
        checks++;
        if (overflow !== ovf_exp || line_err !== 1'b0 || fd_cnt - fd0 != 1) begin
            errors++;
            $display("FAIL bp_flags got ovf=%b lerr=%b pulses=%0d required ovf=%b lerr=0 pulses=1",
                     overflow, line_err, fd_cnt - fd0, ovf_exp);
        end
    endtask

    task automatic test_short_line();
        start_frame();
        fill_random(6);
        send_line(0, 0);
        fill_random(2 * H);
        send_line(1, 0);
        wait_done();
        checks++;
        if (obs_q.size() !== exp_q.size() || obs_q.size() < 4 || obs_q[3][55:32] !== BASE + 24'(H)) begin
            errors++;
            $display("FAIL short_addr got words=%0d required words=%0d addr[3]=%h", obs_q.size(), exp_q.size(), BASE + 24'(H));
        end
        checks++;
        if (line_err !== 1'b1 || fd_cnt - fd0 != 1) begin
            errors++;
            $display("FAIL short_flags got lerr=%b pulses=%0d required lerr=1 pulses=1", line_err, fd_cnt - fd0);
        end
    endtask

    task automatic test_odd_long();
        start_frame();
        for (int l = 0; l < V; l++) begin
            fill_random(2 * H + 4);
            send_line(l, 0);
        end
        wait_done();
        checks++;
        if (obs_q.size() !== V * H || obs_q != exp_q || line_err !== 1'b0) begin
            errors++;
            $display("FAIL long_line got words=%0d lerr=%b required words=%0d lerr=0", obs_q.size(), line_err, V * H);
        end
        start_frame();
        fill_random(9);
        send_line(0, 0);
        fill_random(2 * H);
        send_line(1, 0);
        wait_done();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL odd_count got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL odd_word[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (line_err !== lerr_exp) begin errors++; $display("FAIL odd_lerr got=%b required=%b", line_err, lerr_exp); end
    endtask

    task automatic test_requests();
        start_frame();
        fill_random(2 * H);
        send_line(0, 0);
        cap_req = 1'b1;
        cyc(1'b0, 56'd0);
        cap_req = 1'b0;
        fill_random(2 * H);
        send_line(1, 0);
        wait_done();
        for (int n = 0; n < 10; n++) cyc(1'b0, 56'd0);
        checks++;
        if (fd_cnt - fd0 != 1 || busy !== 1'b0 || obs_q != exp_q) begin
            errors++;
            $display("FAIL req_ignored got pulses=%0d busy=%b words=%0d required pulses=1 busy=0 words=%0d",
                     fd_cnt - fd0, busy, obs_q.size(), exp_q.size());
        end
        start_frame();
        fill_random(2 * H);
        send_line(0, 2);
        vsync = 1'b1;
        lerr_exp = 1'b1;
        cyc(1'b0, 56'd0);
        wait_done();
        vsync = 1'b0;
        cyc(1'b0, 56'd0);
        checks++;
        if (line_err !== lerr_exp || fd_cnt - fd0 != 1 || obs_q != exp_q) begin
            errors++;
            $display("FAIL vsync_abort got lerr=%b pulses=%0d words=%0d required lerr=1 pulses=1 words=%0d",
                     line_err, fd_cnt - fd0, obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        int lens[4];
        lens = '{2 * H, 2 * H - 2, 2 * H + 1, 2 * H + 8};
        for (int f = 0; f < 4; f++) begin
            start_frame();
            for (int l = 0; l < V; l++) begin
                fill_random(lens[$urandom_range(0, 3)]);
                send_line(l, 2);
            end
            wait_done();
            checks++;
            if (obs_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count got=%0d required=%0d", f, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_word[%0d] got=%h required=%h", f, i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (overflow !== ovf_exp || line_err !== lerr_exp || fd_cnt - fd0 != 1) begin
                errors++;
                $display("FAIL rand%0d_flags got ovf=%b lerr=%b pulses=%0d required ovf=%b lerr=%b pulses=1",
                         f, overflow, line_err, fd_cnt - fd0, ovf_exp, lerr_exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_backpressure();
        test_short_line();
        test_odd_long();
        test_requests();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
